// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one single-port synchronous RAM: A (CPU) and B (peripheral)
// share port A of the RAM with round-robin start and bounded bursts under contention.
module mem_port_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_a_i,
  input  logic        we_a_i,
  input  logic [9:0]  addr_a_i,
  input  logic [15:0] wdata_a_i,
  input  logic        req_b_i,
  input  logic        we_b_i,
  input  logic [9:0]  addr_b_i,
  input  logic [15:0] wdata_b_i,
  output logic        gnt_a_o,
  output logic        gnt_b_o,
  output logic        ack_a_o,
  output logic        ack_b_o,
  output logic [15:0] rdata_a_o,
  output logic [15:0] rdata_b_o,
  output logic [9:0]  ram_addr_o,
  output logic [15:0] ram_data_o,
  output logic        ram_we_o,
  input  logic [15:0] ram_q_i
);

  localparam int CW = $clog2(BURST_MAX + 1);
  localparam logic [CW-1:0] BURST_LIM = CW'(BURST_MAX);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_e;

  state_e        state_q, state_d;
  logic          ptr_q, ptr_d;      // 0 = A has priority, 1 = B
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] cnt_sat;
  logic          ack_a_q, ack_b_q;
  logic          beat_a, beat_b;

  assign cnt_sat = (cnt_q == BURST_LIM) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
      ack_a_q <= 1'b0;
      ack_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ack_a_q <= beat_a;
      ack_b_q <= beat_b;
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    beat_a     = 1'b0;
    beat_b     = 1'b0;
    ram_addr_o = '0;
    ram_data_o = '0;
    ram_we_o   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_a_i && req_b_i) state_d = ptr_q ? OWN_B : OWN_A;
        else if (req_a_i)       state_d = OWN_A;
        else if (req_b_i)       state_d = OWN_B;
      end
      OWN_A: begin
        ram_addr_o = addr_a_i;
        ram_data_o = wdata_a_i;
        ram_we_o   = we_a_i & req_a_i;
        if (req_a_i) begin
          beat_a = 1'b1;
          cnt_d  = cnt_sat;
          if (cnt_sat == BURST_LIM && req_b_i) state_d = OWN_B;
        end else begin
          state_d = req_b_i ? OWN_B : IDLE;
        end
      end
      OWN_B: begin
        ram_addr_o = addr_b_i;
        ram_data_o = wdata_b_i;
        ram_we_o   = we_b_i & req_b_i;
        if (req_b_i) begin
          beat_b = 1'b1;
          cnt_d  = cnt_sat;
          if (cnt_sat == BURST_LIM && req_a_i) state_d = OWN_A;
        end else begin
          state_d = req_a_i ? OWN_A : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Any change of owner restarts the burst count and hands priority to the other side.
    if (state_d != state_q) cnt_d = '0;
    if (state_q == OWN_A && state_d != OWN_A) ptr_d = 1'b1;
    if (state_q == OWN_B && state_d != OWN_B) ptr_d = 1'b0;
  end

  assign gnt_a_o   = (state_q == OWN_A);
  assign gnt_b_o   = (state_q == OWN_B);
  assign ack_a_o   = ack_a_q;
  assign ack_b_o   = ack_b_q;
  assign rdata_a_o = ram_q_i;
  assign rdata_b_o = ram_q_i;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural 1-cycle-latency RAM on the port.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_a = 1'b0, we_a = 1'b0, req_b = 1'b0, we_b = 1'b0;
  logic [9:0]  addr_a = '0, addr_b = '0;
  logic [15:0] wdata_a = '0, wdata_b = '0;
  logic        gnt_a, gnt_b, ack_a, ack_b, ram_we;
  logic [15:0] rdata_a, rdata_b, ram_data;
  logic [15:0] ram_q = '0;
  logic [9:0]  ram_addr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] mem [1024];
  bit          written [1024];

  always #5 clk = ~clk;

  mem_port_arbiter #(.BURST_MAX(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_a_i(req_a), .we_a_i(we_a), .addr_a_i(addr_a), .wdata_a_i(wdata_a),
    .req_b_i(req_b), .we_b_i(we_b), .addr_b_i(addr_b), .wdata_b_i(wdata_b),
    .gnt_a_o(gnt_a), .gnt_b_o(gnt_b), .ack_a_o(ack_a), .ack_b_o(ack_b),
    .rdata_a_o(rdata_a), .rdata_b_o(rdata_b),
    .ram_addr_o(ram_addr), .ram_data_o(ram_data), .ram_we_o(ram_we),
    .ram_q_i(ram_q)
  );

  // Unwritten locations read back a fixed pattern; 0x010 holds 0xBEEF.
  function automatic logic [15:0] init_val(input logic [9:0] a);
    return (a == 10'h010) ? 16'hBEEF : 16'h1000 + {6'h0, a};
  endfunction

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr]     <= ram_data;
      written[ram_addr] <= 1'b1;
    end
    ram_q <= written[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
    req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_a, prev_a;

    // Reset state
    #2;
    check_eq("rst_gnt_a", gnt_a, 0);
    check_eq("rst_gnt_b", gnt_b, 0);
    check_eq("rst_ack", {ack_a, ack_b}, 0);
    check_eq("rst_ram_we", ram_we, 0);
    check_eq("rst_ram_addr", ram_addr, 0);
    do_reset();

    // Single A read of 0x010
    $display("txn: A read 0x010");
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'h010;
    #1 check_eq("rd_a_no_gnt_c1", gnt_a, 0);
    tick();
    check_eq("rd_a_gnt_c2", gnt_a, 1);
    check_eq("rd_a_gnt_b_c2", gnt_b, 0);
    check_eq("rd_a_ack_c2", ack_a, 0);
    #1 check_eq("rd_a_ram_addr", ram_addr, 10'h010);
    check_eq("rd_a_ram_we", ram_we, 0);
    tick();
    check_eq("rd_a_ack_c3", ack_a, 1);
    check_eq("rd_a_rdata", rdata_a, 16'hBEEF);
    req_a = 1'b0;
    tick();
    check_eq("rd_a_idle_gnt", gnt_a, 0);
    check_eq("rd_a_idle_ack", ack_a, 0);

    // B writes 0x1234 to 0x3FF then reads it back
    $display("txn: B write/read 0x3FF");
    req_b = 1'b1; we_b = 1'b1; addr_b = 10'h3FF; wdata_b = 16'h1234;
    #1 check_eq("wr_b_we_before_gnt", ram_we, 0);
    tick();
    check_eq("wr_b_gnt", gnt_b, 1);
    #1 check_eq("wr_b_ram_we", ram_we, 1);
    check_eq("wr_b_ram_addr", ram_addr, 10'h3FF);
    check_eq("wr_b_ram_data", ram_data, 16'h1234);
    tick();
    check_eq("wr_b_ack", ack_b, 1);
    we_b = 1'b0;
    #1 check_eq("rd_b_ram_we", ram_we, 0);
    tick();
    check_eq("rd_b_ack", ack_b, 1);
    check_eq("rd_b_rdata", rdata_b, 16'h1234);
    req_b = 1'b0;
    tick();
    check_eq("rd_b_idle_gnt", gnt_b, 0);
    check_eq("rd_b_idle_ack", ack_b, 0);

    // Simultaneous requests after reset, A holds two beats
    do_reset();
    $display("txn: A+B together, A two beats");
    req_a = 1'b1; addr_a = 10'h001; req_b = 1'b1; addr_b = 10'h002;
    tick();
    check_eq("both_gnt_a_c2", gnt_a, 1);
    check_eq("both_gnt_b_c2", gnt_b, 0);
    tick();
    check_eq("both_gnt_a_c3", gnt_a, 1);
    check_eq("both_ack_a_c3", ack_a, 1);
    check_eq("both_rdata_a_c3", rdata_a, 16'h1001);
    tick();
    check_eq("both_ack_a_c4", ack_a, 1);
    req_a = 1'b0;
    tick();
    check_eq("both_gnt_b_c5", gnt_b, 1);
    check_eq("both_gnt_a_c5", gnt_a, 0);
    check_eq("both_ack_a_c5", ack_a, 0);
    tick();
    check_eq("both_ack_b_c6", ack_b, 1);
    check_eq("both_rdata_b_c6", rdata_b, 16'h1002);
    clear_inputs();
    repeat (2) tick();

    // Sustained contention: A x4, B x4, A x4, B x4
    do_reset();
    $display("txn: sustained contention, BURST_MAX=4");
    req_a = 1'b1; addr_a = 10'h020; req_b = 1'b1; addr_b = 10'h030;
    prev_a = 1'b0;
    for (int k = 2; k <= 17; k++) begin
      tick();
      exp_a = (((k - 2) / 4) % 2) == 0;
      check_eq($sformatf("rr_gnt_a[%0d]", k), gnt_a, exp_a);
      check_eq($sformatf("rr_gnt_b[%0d]", k), gnt_b, !exp_a);
      if (k >= 3) begin
        check_eq($sformatf("rr_ack_a[%0d]", k), ack_a, prev_a);
        check_eq($sformatf("rr_ack_b[%0d]", k), ack_b, !prev_a);
        check_eq($sformatf("rr_rdata[%0d]", k), prev_a ? rdata_a : rdata_b,
                 prev_a ? 16'h1020 : 16'h1030);
      end
      prev_a = exp_a;
    end
    clear_inputs();
    repeat (2) tick();

    // A streams alone, B arrives on beat 6
    do_reset();
    $display("txn: A long burst, B arrives at beat 6");
    req_a = 1'b1; addr_a = 10'h040;
    for (int k = 2; k <= 7; k++) begin
      tick();
      check_eq($sformatf("long_gnt_a[%0d]", k), gnt_a, 1);
      check_eq($sformatf("long_gnt_b[%0d]", k), gnt_b, 0);
      if (k == 7) req_b = 1'b1;
    end
    tick();
    check_eq("long_gnt_b_c8", gnt_b, 1);
    check_eq("long_gnt_a_c8", gnt_a, 0);
    check_eq("long_ack_a_c8", ack_a, 1);
    check_eq("long_ack_b_c8", ack_b, 0);
    req_a = 1'b0; req_b = 1'b0;
    tick();
    check_eq("long_idle_gnt_b", gnt_b, 0);
    check_eq("long_no_ack_b", ack_b, 0);

    // Reset in the middle of a B burst
    do_reset();
    $display("txn: reset during B burst");
    req_b = 1'b1; we_b = 1'b1; addr_b = 10'h050; wdata_b = 16'hAAAA;
    tick();
    check_eq("mid_gnt_b_c2", gnt_b, 1);
    tick();
    check_eq("mid_ack_b_c3", ack_b, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_gnt_b", gnt_b, 0);
    check_eq("mid_rst_ack_b", ack_b, 0);
    check_eq("mid_rst_ram_we", ram_we, 0);
    check_eq("mid_rst_ram_addr", ram_addr, 0);
    check_eq("mid_rst_ram_data", ram_data, 0);
    req_a = 1'b1; we_a = 1'b0; addr_a = 10'h060; we_b = 1'b0;
    tick();
    check_eq("mid_rst_ack_b_held", ack_b, 0);
    check_eq("mid_rst_gnt_a_held", gnt_a, 0);
    rst_n = 1'b1;
    tick();
    check_eq("mid_post_gnt_a", gnt_a, 1);
    check_eq("mid_post_gnt_b", gnt_b, 0);
    tick();
    check_eq("mid_post_ack_a", ack_a, 1);
    check_eq("mid_post_rdata_a", rdata_a, 16'h1060);

    // Pointer moves to B after A's ownership ends
    do_reset();
    $display("txn: pointer hand-off after A-only burst");
    req_a = 1'b1; addr_a = 10'h070;
    tick();
    check_eq("ptr_gnt_a_c2", gnt_a, 1);
    tick();
    req_a = 1'b0;
    tick();
    check_eq("ptr_idle_gnt", {gnt_a, gnt_b}, 0);
    req_a = 1'b1; req_b = 1'b1; addr_b = 10'h071;
    tick();
    check_eq("ptr_gnt_b_first", gnt_b, 1);
    check_eq("ptr_gnt_a_not", gnt_a, 0);
    clear_inputs();
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: BURST_MAX, default 4, maximum consecutive beats an owner keeps the port while the other requester is waiting.
REQ-002 Clk  input  1  single clock; all state updates on rising edge.
REQ-003 Rst  input  1  reset, asynchronous and active-low.
REQ-004 ReqA / ReqB  input  1  requester A (CPU) / B (peripheral) access request.
REQ-005 WeA / WeB  input  1  1 = write beat, 0 = read beat.
REQ-006 AddrA / AddrB  input  10  word address.
REQ-007 WDataA / WDataB  input  16  write data.
REQ-008 GntA / GntB  output  1  requester owns the RAM port this cycle.
REQ-009 AckA / AckB  output  1  previous-cycle beat completed; read data valid.
REQ-010 RDataA / RDataB  output  16  read data, both driven from RamQ.
REQ-011 RamAddr  output  10  to RAM port A address.
REQ-012 RamData  output  16  to RAM port A write data.
REQ-013 RamWe  output  1  to RAM port A write enable.
REQ-014 RamQ  input  16  RAM port A registered read data (1-cycle latency).

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, OWN_A, OWN_B; state, priority pointer, burst counter and Ack flops are registered.
REQ-016 GntA SHALL equal (state==OWN_A) and GntB SHALL equal (state==OWN_B), decoded from registered state only.
REQ-017 In OWN_x, RamAddr/RamData SHALL mux combinationally from requester x, and RamWe SHALL be WeX AND ReqX; in IDLE, RamAddr=0, RamData=0, RamWe=0.
REQ-018 A beat SHALL occur on each cycle where GntX and ReqX are both 1; the requester holds Addr/We/WData stable until it sees Gnt and may change them after each beat.
REQ-019 AckX SHALL be 1 exactly one cycle after each beat of x (reads and writes), with RDataX=RamQ valid in that cycle for reads.
REQ-020 IDLE with only one Req SHALL go to that owner next cycle; with both Req, it goes to the pointer side (pointer resets to A).
REQ-021 On leaving OWN_x, the pointer SHALL move to the other requester.
REQ-022 The burst counter SHALL reset to 0 on entry to an OWN state, increment per beat, and saturate at BURST_MAX.
REQ-023 In OWN_x with ReqX=0, the FSM SHALL move to the other OWN state if the other Req=1, else to IDLE; no beat and no Ack occur that cycle.
REQ-024 In OWN_x, when a beat brings the count to BURST_MAX and the other Req=1, the FSM SHALL move directly to the other OWN state with no idle cycle.
REQ-025 In OWN_x with the other Req=0, x SHALL keep ownership indefinitely; the counter saturates and handover occurs on the first cycle the other Req rises at saturation.
REQ-026 Latency: Req rising in IDLE at cycle n SHALL give Gnt at n+1 and Ack at n+2; a sustained owner completes one beat per cycle.
REQ-027 Gnt SHALL never be asserted to both requesters in the same cycle, and RamWe SHALL never be 1 without a Gnt.

Reset
REQ-028 Rst=0 SHALL asynchronously force state=IDLE, pointer=A, counter=0, GntA=GntB=AckA=AckB=0, RamWe=0, RamAddr=0, RamData=0.
REQ-029 A reset mid-burst SHALL drop any pending Ack; the first grant after release follows REQ-020.

Verification
REQ-030 RAM[0x010]=0xBEEF; ReqA=1 read 0x010 at cycle 1 -> GntA cycle 2, AckA cycle 3, RDataA=0xBEEF.
REQ-031 B writes 0x1234 to 0x3FF, then reads 0x3FF -> RamWe=1 only on the write beat, AckB on both beats, read RDataB=0x1234.
REQ-032 ReqA and ReqB rise together after reset, A holds 2 beats -> GntA for 2 beats, then GntB with no gap cycle, pointer=B.
REQ-033 Both Req held continuously, BURST_MAX=4 -> beats alternate A×4, B×4, A×4 with 100% port utilization, never both Gnt.
REQ-034 A holds 10 beats, B idle; B rises at beat 6 -> A keeps beats 1-6, GntB starts the next cycle.
REQ-035 Rst pulsed low during OWN_B burst -> all outputs 0 immediately, no Ack for the interrupted beat, and A is granted first after release if both request.
